// File: rtl/bar_ram_writer.sv
// Reads left-channel audio samples from a FIFO and sums their magnitudes into bars.
// Each bar height is written to a small RAM, and a strobe marks each finished frame.
module bar_ram_writer #(
  parameter int SAMPLES_PER_BAR = 64,
  parameter int NUM_BARS        = 20,
  parameter int SHIFT           = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_q,
  input  logic        fifo_rdempty,
  output logic        fifo_rdreq,
  input  logic        rd_busy,
  output logic [5:0]  ram_wraddress,
  output logic [5:0]  ram_data,
  output logic        ram_wren,
  output logic        data_back,
  output logic [2:0]  dbg_state
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BAR) + 1;
  // The worst case is SAMPLES_PER_BAR * 32768, so the sum must hold that without wrapping.
  localparam int SUM_W = (16 + $clog2(SAMPLES_PER_BAR) > 22) ? 16 + $clog2(SAMPLES_PER_BAR) : 22;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         bar_q, bar_d;
  logic               hold_q, hold_d;
  logic               rdreq_q, rdreq_d;
  logic               wren_q, wren_d;
  logic [5:0]         wraddr_q, wraddr_d;
  logic [5:0]         wdata_q, wdata_d;
  logic               dback_q, dback_d;

  logic signed [16:0] s_ext;
  logic [16:0]        mag;
  logic [SUM_W-1:0]   shifted;
  logic [5:0]         height;
  logic               unused_low;

  assign unused_low = ^fifo_q[15:0];

  // FIFO handshake: a word is popped only when rdempty is low. rdreq is a one-cycle pulse,
  // and the popped word is valid on fifo_q in the following cycle (the CAPT state).
  always_comb begin
    s_ext    = {fifo_q[31], fifo_q[31:16]};
    mag      = s_ext[16] ? 17'(-s_ext) : 17'(s_ext);
    shifted  = sum_q >> SHIFT;
    height   = (shifted > SUM_W'(63)) ? 6'd63 : shifted[5:0];

    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    bar_d    = bar_q;
    hold_d   = hold_q;
    rdreq_d  = 1'b0;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    wdata_d  = wdata_q;
    dback_d  = 1'b0;

    case (state_q)
      S_REQ: begin
        if (!fifo_rdempty) begin
          rdreq_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        sum_d = sum_q + SUM_W'(mag);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SAMPLES_PER_BAR - 1)) state_d = S_WRITE;
        else                                       state_d = S_REQ;
      end
      S_WRITE: begin
        wren_d   = 1'b1;
        wraddr_d = bar_q;
        wdata_d  = height;
        sum_d    = '0;
        cnt_d    = '0;
        if (bar_q == 6'(NUM_BARS - 1)) begin
          bar_d   = '0;
          state_d = S_DONE;
        end else begin
          bar_d   = bar_q + 6'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        dback_d = 1'b1;
        hold_d  = 1'b0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // The first HOLD cycle always stalls. This gives the reader time to raise rd_busy.
        hold_d = 1'b1;
        if (hold_q && !rd_busy) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      sum_q    <= '0;
      cnt_q    <= '0;
      bar_q    <= '0;
      hold_q   <= 1'b0;
      rdreq_q  <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wdata_q  <= '0;
      dback_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      bar_q    <= bar_d;
      hold_q   <= hold_d;
      rdreq_q  <= rdreq_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
      dback_q  <= dback_d;
    end
  end

  assign fifo_rdreq    = rdreq_q;
  assign ram_wren      = wren_q;
  assign ram_wraddress = wraddr_q;
  assign ram_data      = wdata_q;
  assign data_back     = dback_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bar_ram_writer.sv
// Directed bench for bar_ram_writer: a FIFO model feeds fixed sample patterns,
// and each observed RAM write and frame strobe is checked against hand-computed bars.
module tb_bar_ram_writer;
  localparam int NB      = 20;
  localparam int TIMEOUT = 6000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_q;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic        rd_busy;
  logic [5:0]  ram_wraddress;
  logic [5:0]  ram_data;
  logic        ram_wren;
  logic        data_back;
  logic [2:0]  dbg_state;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bar_ram_writer dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_q        (fifo_q),
    .fifo_rdempty  (fifo_rdempty),
    .fifo_rdreq    (fifo_rdreq),
    .rd_busy       (rd_busy),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .data_back     (data_back),
    .dbg_state     (dbg_state)
  );

  // FIFO model: each rdreq pops a word, and the next word appears on fifo_q one cycle later.
  // Patterns: 0 = +0x4000, 1 = 0x8000 (-32768), 2 = alternating +/-0x2000.
  logic [1:0]  mode = 2'd0;
  int unsigned rd_total = 0;
  logic [15:0] left;
  always @(posedge clk) if (fifo_rdreq) rd_total <= rd_total + 1;
  always_comb begin
    left = 16'h4000;
    case (mode)
      2'd1:    left = 16'h8000;
      2'd2:    left = rd_total[0] ? 16'h2000 : 16'hE000;
      default: left = 16'h4000;
    endcase
    fifo_q = {left, 16'hA5A5};
  end

  // Monitor: record writes, frame strobes and read requests, sampling at the falling edge.
  int          cyc = 0;
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  int          wr_cyc_q[$];
  int          db_cyc_q[$];
  int          rdreq_cnt = 0;
  int          dbl_rdreq = 0;
  logic        prev_rdreq = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_wren) begin
      obs_q.push_back({ram_wraddress, ram_data});
      wr_cyc_q.push_back(cyc);
    end
    if (data_back) db_cyc_q.push_back(cyc);
    if (fifo_rdreq) rdreq_cnt++;
    if (fifo_rdreq && prev_rdreq) dbl_rdreq++;
    prev_rdreq = fifo_rdreq;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    wr_cyc_q.delete();
    db_cyc_q.delete();
    rdreq_cnt = 0;
    dbl_rdreq = 0;
  endtask

  task automatic fill_exp(input logic [5:0] h);
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back({6'(i), h});
  endtask

  task automatic wait_db(output bit ok);
    int n = 0;
    while (db_cyc_q.size() == 0 && n < TIMEOUT) begin
      tick();
      n++;
    end
    ok = (db_cyc_q.size() != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifo_rdempty = 1'b1;
    rd_busy = 1'b0;
    repeat (5) tick();
    compared += 5;
    if (fifo_rdreq !== 1'b0) begin mismatched++; $display("FAIL reset_rdreq: got %b want 0", fifo_rdreq); end
    if (ram_wren !== 1'b0) begin mismatched++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
    if (data_back !== 1'b0) begin mismatched++; $display("FAIL reset_data_back: got %b want 0", data_back); end
    if (ram_wraddress !== 6'd0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", ram_wraddress); end
    if (ram_data !== 6'd0) begin mismatched++; $display("FAIL reset_data: got %0d want 0", ram_data); end
    reset = 1'b0;
    clear_obs();
    repeat (100) tick();
    compared++;
    if (rdreq_cnt !== 0) begin mismatched++; $display("FAIL idle_no_rdreq: got %0d requests want 0", rdreq_cnt); end
  endtask

  task automatic test_frame(input string name, input logic [1:0] m, input logic [5:0] h);
    bit ok;
    mode = m;
    fill_exp(h);
    clear_obs();
    fifo_rdempty = 1'b0;
    wait_db(ok);
    fifo_rdempty = 1'b1;
    repeat (4) tick();
    compared++;
    if (!ok) begin mismatched++; $display("FAIL %s_timeout: no data_back after %0d cycles, want 1 pulse", name, TIMEOUT); end
    compared++;
    if (obs_q.size() != NB) begin mismatched++; $display("FAIL %s_wr_count: got %0d want %0d", name, obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL %s_bar%0d: got addr %0d data %0d want addr %0d data %0d",
                 name, i, obs_q[i][11:6], obs_q[i][5:0], exp_q[i][11:6], exp_q[i][5:0]);
      end
    end
    compared++;
    if (db_cyc_q.size() != 1) begin mismatched++; $display("FAIL %s_db_count: got %0d pulses want 1", name, db_cyc_q.size()); end
    if (db_cyc_q.size() != 0 && wr_cyc_q.size() != 0) begin
      compared++;
      if (db_cyc_q[0] != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
        mismatched++;
        $display("FAIL %s_db_timing: got cycle %0d want %0d", name, db_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
      end
    end
    compared++;
    if (dbl_rdreq != 0) begin mismatched++; $display("FAIL %s_rdreq_pulse: got %0d back-to-back want 0", name, dbl_rdreq); end
  endtask

  task automatic test_stall();
    bit ok;
    int n = 0;
    mode = 2'd0;
    fill_exp(6'd32);
    clear_obs();
    fifo_rdempty = 1'b0;
    while (rdreq_cnt < 3 * 64 + 30 && n < TIMEOUT) begin tick(); n++; end
    fifo_rdempty = 1'b1;
    repeat (100) tick();
    compared += 2;
    if (rdreq_cnt != 222) begin mismatched++; $display("FAIL stall_rdreq: got %0d requests want 222", rdreq_cnt); end
    if (obs_q.size() != 3) begin mismatched++; $display("FAIL stall_writes: got %0d want 3", obs_q.size()); end
    fifo_rdempty = 1'b0;
    wait_db(ok);
    fifo_rdempty = 1'b1;
    repeat (4) tick();
    compared += 2;
    if (!ok) begin mismatched++; $display("FAIL stall_timeout: no data_back after %0d cycles, want 1 pulse", TIMEOUT); end
    if (obs_q.size() != NB) begin mismatched++; $display("FAIL stall_wr_count: got %0d want %0d", obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL stall_bar%0d: got addr %0d data %0d want addr %0d data %0d",
                 i, obs_q[i][11:6], obs_q[i][5:0], exp_q[i][11:6], exp_q[i][5:0]);
      end
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int rq0, w0, n;
    mode = 2'd0;
    fill_exp(6'd32);
    clear_obs();
    fifo_rdempty = 1'b0;
    wait_db(ok);
    rd_busy = 1'b1;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL busy_timeout: no data_back after %0d cycles, want 1 pulse", TIMEOUT); end
    rq0 = rdreq_cnt;
    w0 = obs_q.size();
    repeat (50) tick();
    rd_busy = 1'b0;
    tick();
    compared += 2;
    if (rdreq_cnt != rq0) begin mismatched++; $display("FAIL busy_rdreq: got %0d requests want %0d", rdreq_cnt, rq0); end
    if (obs_q.size() != w0) begin mismatched++; $display("FAIL busy_wren: got %0d writes want %0d", obs_q.size(), w0); end
    n = 0;
    while (rdreq_cnt == rq0 && n < 6) begin tick(); n++; end
    compared++;
    if (rdreq_cnt == rq0) begin mismatched++; $display("FAIL busy_resume: got no rdreq want one within 6 cycles"); end
    clear_obs();
    wait_db(ok);
    fifo_rdempty = 1'b1;
    repeat (4) tick();
    compared += 2;
    if (!ok) begin mismatched++; $display("FAIL busy_frame2_timeout: no data_back after %0d cycles, want 1 pulse", TIMEOUT); end
    if (obs_q.size() != NB) begin mismatched++; $display("FAIL busy_frame2_count: got %0d want %0d", obs_q.size(), NB); end
    if (obs_q.size() != 0) begin
      compared++;
      if (obs_q[0] !== exp_q[0]) begin
        mismatched++;
        $display("FAIL busy_frame2_first: got addr %0d data %0d want addr 0 data 32", obs_q[0][11:6], obs_q[0][5:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n = 0;
    mode = 2'd0;
    fill_exp(6'd32);
    clear_obs();
    fifo_rdempty = 1'b0;
    while (rdreq_cnt < 6 * 64 + 10 && n < TIMEOUT) begin tick(); n++; end
    compared++;
    if (obs_q.size() != 6) begin mismatched++; $display("FAIL midrst_pre_writes: got %0d want 6", obs_q.size()); end
    reset = 1'b1;
    tick();
    compared += 5;
    if (fifo_rdreq !== 1'b0) begin mismatched++; $display("FAIL midrst_rdreq: got %b want 0", fifo_rdreq); end
    if (ram_wren !== 1'b0) begin mismatched++; $display("FAIL midrst_wren: got %b want 0", ram_wren); end
    if (data_back !== 1'b0) begin mismatched++; $display("FAIL midrst_data_back: got %b want 0", data_back); end
    if (ram_wraddress !== 6'd0) begin mismatched++; $display("FAIL midrst_addr: got %0d want 0", ram_wraddress); end
    if (ram_data !== 6'd0) begin mismatched++; $display("FAIL midrst_data: got %0d want 0", ram_data); end
    reset = 1'b0;
    clear_obs();
    wait_db(ok);
    fifo_rdempty = 1'b1;
    repeat (4) tick();
    compared += 2;
    if (!ok) begin mismatched++; $display("FAIL midrst_timeout: no data_back after %0d cycles, want 1 pulse", TIMEOUT); end
    if (obs_q.size() != NB) begin mismatched++; $display("FAIL midrst_wr_count: got %0d want %0d", obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL midrst_bar%0d: got addr %0d data %0d want addr %0d data %0d",
                 i, obs_q[i][11:6], obs_q[i][5:0], exp_q[i][11:6], exp_q[i][5:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    fifo_rdempty = 1'b1;
    rd_busy = 1'b0;
    test_reset();
    test_frame("const4000", 2'd0, 6'd32);
    test_frame("sat8000", 2'd1, 6'd63);
    test_frame("alt2000", 2'd2, 6'd16);
    test_stall();
    test_busy_hold();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bar_ram_writer.md
BAR_RAM_WRITER -- requirements
Module: bar_ram_writer

Interface
REQ-001 Parameter SAMPLES_PER_BAR, default 64, meaning samples summed per bar (power of two, 2..256).
REQ-002 Parameter NUM_BARS, default 20, meaning bars per frame, written to RAM addresses 0..NUM_BARS-1 (max 64).
REQ-003 Parameter SHIFT, default 15, meaning right-shift applied to the bar sum to form the height.
REQ-004 clk  input  1  single clock (CLOCK_50 domain); all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fifo_q  input  32  FIFO read data; [31:16] left sample, signed two's complement; [15:0] ignored.
REQ-007 fifo_rdempty  input  1  FIFO read-side empty flag.
REQ-008 fifo_rdreq  output  1  FIFO read request, registered.
REQ-009 rd_busy  input  1  frame reader copying RAM; high blocks the next frame.
REQ-010 ram_wraddress  output  6  bar RAM write address, registered.
REQ-011 ram_data  output  6  bar height, registered.
REQ-012 ram_wren  output  1  bar RAM write enable, registered.
REQ-013 data_back  output  1  frame-complete strobe, registered; reader detects its rising edge.

Function
REQ-014 States: REQ, WAIT, CAPT, WRITE, DONE, HOLD; exactly one active per cycle.
REQ-015 REQ: fifo_rdempty=0 -> fifo_rdreq=1 next cycle, go WAIT; fifo_rdempty=1 -> stay, fifo_rdreq=0, sum and counters unchanged.
REQ-016 WAIT: fifo_rdreq high for this cycle only; go CAPT (FIFO normal mode, q valid the cycle after rdreq).
REQ-017 CAPT: add |fifo_q[31:16]| to 22-bit sum; |-32768| = 32768, no wrap; increment sample count; count reaches SAMPLES_PER_BAR -> WRITE, else REQ.
REQ-018 One sample therefore costs 3 cycles minimum; fifo_rdreq never high in two consecutive cycles.
REQ-019 WRITE: ram_wren=1 for exactly one cycle, ram_wraddress = bar index, ram_data = min(63, sum >> SHIFT); sum and sample count cleared.
REQ-020 After WRITE: bar index = NUM_BARS-1 -> DONE with index reset to 0; else index+1 -> REQ.
REQ-021 DONE: data_back=1 for exactly one cycle; go HOLD.
REQ-022 HOLD: at least 2 cycles; exits to REQ on the first cycle after that with rd_busy=0; no fifo_rdreq, no ram_wren while in HOLD.
REQ-023 ram_wraddress and ram_data hold their last values when ram_wren=0.
REQ-024 Sums are never carried between bars or frames; each bar is exactly SAMPLES_PER_BAR consecutive FIFO words.

Reset
REQ-025 reset=1: state REQ, sum 0, sample count 0, bar index 0; fifo_rdreq, ram_wren, data_back, ram_wraddress, ram_data all 0 in the following cycle.
REQ-026 Reset mid-frame or mid-sample discards partial results; no further write of the aborted bar; a pending rdreq is not reissued.
REQ-027 Reset has priority over all state transitions in the same cycle.

Verification
REQ-028 Reset held 5 cycles, rdempty=1 -> all outputs 0; no rdreq for 100 cycles after release.
REQ-029 FIFO always non-empty, left=0x4000 for 1280 words -> 20 writes, addresses 0..19, data 32 each; one data_back pulse one cycle after address 19 write.
REQ-030 Left=0x8000 (-32768) for all words -> every ram_data=63 (sum 2097152>>15=64 saturated); left alternating +/-0x2000 -> 16.
REQ-031 rdempty forced 1 for 100 cycles after 30 samples of bar 3 -> no rdreq during stall; bar 3 value identical to the unstalled run.
REQ-032 rd_busy=1 from 1 cycle after data_back for 50 cycles -> no rdreq or ram_wren until 1 cycle after rd_busy falls; next frame starts at address 0.
REQ-033 Reset pulse after bar 5 written, mid-bar 6 -> no write to address 6 from the aborted bar; next write at address 0 with a fresh 64-sample sum.
